// File: rtl/snake_pkg.sv
`default_nettype none
// ============================================================================
// Module      : snake_pkg
// Description : Shared definitions for the LCD message scheduler. Holds the
//               controller state encoding, the carriage-return character that
//               ends every message, and the gap counter width.
// Revision    : 1.0  initial release
// ============================================================================
package snake_pkg;

    // Controller states. IDLE is the only state in which no requester owns
    // the LCD text port.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_GAP  = 2'd2,
        ST_CR   = 2'd3
    } state_e;

    // Character appended automatically after the last byte of every message.
    localparam logic [7:0] CR_CHAR = 8'h0D;

    // Width of the inter-write gap counter.
    localparam int GAP_CNT_W = 16;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Purely combinational round-robin selector. Returns a one-hot
//               pick of the first asserted request found when searching from
//               index last+1 upward with wrap-around. All-zero when no
//               request is asserted.
// Ports       : req  - request vector (one bit per requester)
//               last - index of the requester served most recently
//               pick - one-hot selected requester
// Revision    : 1.0  initial release
// ============================================================================
module rr_pick
    import snake_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDXW = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] last,
    output logic [NREQ-1:0] pick
);

    // lowest_above : lowest asserted request with index strictly above last
    // lowest_any   : lowest asserted request overall (the wrap-around case)
    logic [NREQ-1:0] lowest_above;
    logic [NREQ-1:0] lowest_any;

    always_comb begin
        lowest_above = '0;
        lowest_any   = '0;
        // Scanning downward lets the final hit be the lowest index.
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (req[j]) begin
                lowest_any    = '0;
                lowest_any[j] = 1'b1;
                if (j > int'(last)) begin
                    lowest_above    = '0;
                    lowest_above[j] = 1'b1;
                end
            end
        end
        pick = (|lowest_above) ? lowest_above : lowest_any;
    end

endmodule
`default_nettype wire

// File: rtl/lcd_msg_sched.sv
`default_nettype none
// ============================================================================
// Module      : lcd_msg_sched
// Description : Arbitrates several byte-stream message requesters onto a
//               single LCD character writer. One requester at a time owns the
//               port for a whole message; its bytes are forwarded unchanged,
//               consecutive write strobes are spaced by GAP_CYCLES idle
//               cycles, and a carriage return is appended after the byte
//               flagged as last. Ownership rotates round-robin.
// Ports       : clock     - system clock, rising edge
//               reset     - synchronous reset, active low
//               req_valid - per-requester byte valid
//               req_data  - per-requester byte, requester i in [8i+7:8i]
//               req_last  - final byte of a message (qualified by req_valid)
//               req_ready - per-requester accept, equals grant while in XFER
//               grant     - one-hot owner of the LCD port, zero when idle
//               write_en  - one-cycle write strobe to the character writer
//               data      - character byte, valid while write_en is high
//               busy      - high whenever the controller is not idle
// Revision    : 1.0  initial release
// ============================================================================
module lcd_msg_sched
    import snake_pkg::*;
#(
    parameter int NREQ       = 2,
    parameter int GAP_CYCLES = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [8*NREQ-1:0]   req_data,
    input  logic [NREQ-1:0]     req_last,
    output logic [NREQ-1:0]     req_ready,
    output logic [NREQ-1:0]     grant,
    output logic                write_en,
    output logic [7:0]          data,
    output logic                busy
);

    localparam int                   IDXW     = (NREQ > 1) ? $clog2(NREQ) : 1;
    // The counter runs from GAP_CYCLES-1 down to 0 and is reloaded before it
    // could ever wrap, so GAP lasts exactly GAP_CYCLES cycles.
    localparam logic [GAP_CNT_W-1:0] GAP_LOAD = GAP_CNT_W'(GAP_CYCLES - 1);
    // Resetting last_owner to the top index makes requester 0 win first.
    localparam logic [IDXW-1:0]      LAST_RST = IDXW'(NREQ - 1);

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    state_e                 state_q,      state_d;
    logic [NREQ-1:0]        grant_q,      grant_d;
    logic [IDXW-1:0]        last_owner_q, last_owner_d;
    logic [GAP_CNT_W-1:0]   cnt_q,        cnt_d;
    logic                   last_flag_q,  last_flag_d;
    logic                   done_q,       done_d;
    logic                   write_en_q,   write_en_d;
    logic [7:0]             data_q,       data_d;

    // ------------------------------------------------------------------------
    // Round-robin selection among currently valid requesters
    // ------------------------------------------------------------------------
    logic [NREQ-1:0]        pick;

    rr_pick #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_rr_pick (
        .req  (req_valid),
        .last (last_owner_q),
        .pick (pick)
    );

    // ------------------------------------------------------------------------
    // Owner view: the granted requester's byte, valid, last and index.
    // Grant is one-hot, so an OR-reduction under the grant mask selects it.
    // ------------------------------------------------------------------------
    logic                   owner_valid;
    logic                   owner_last;
    logic [7:0]             owner_byte;
    logic [IDXW-1:0]        owner_idx;

    assign owner_valid = |(req_valid & grant_q);
    assign owner_last  = |(req_last  & grant_q);

    always_comb begin
        owner_byte = 8'h00;
        owner_idx  = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (grant_q[j]) begin
                owner_byte = req_data[8*j +: 8];
                owner_idx  = IDXW'(j);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_owner_d = last_owner_q;
        cnt_d        = cnt_q;
        last_flag_d  = last_flag_q;
        done_d       = done_q;
        write_en_d   = 1'b0;
        data_d       = data_q;

        case (state_q)
            ST_IDLE: begin
                if (|req_valid) begin
                    grant_d = pick;
                    state_d = ST_XFER;
                end
            end

            ST_XFER: begin
                // A stalled owner simply keeps the block here; grant holds.
                if (owner_valid) begin
                    data_d      = owner_byte;
                    write_en_d  = 1'b1;
                    last_flag_d = owner_last;
                    cnt_d       = GAP_LOAD;
                    state_d     = ST_GAP;
                end
            end

            ST_GAP: begin
                if (cnt_q == '0) begin
                    if (done_q) begin
                        // Trailing CR has been spaced out: release the port.
                        grant_d      = '0;
                        last_owner_d = owner_idx;
                        done_d       = 1'b0;
                        state_d      = ST_IDLE;
                    end else if (last_flag_q) begin
                        state_d = ST_CR;
                    end else begin
                        state_d = ST_XFER;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            ST_CR: begin
                write_en_d  = 1'b1;
                data_d      = CR_CHAR;
                last_flag_d = 1'b0;
                cnt_d       = GAP_LOAD;
                done_d      = 1'b1;
                state_d     = ST_GAP;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_owner_q <= LAST_RST;
            cnt_q        <= '0;
            last_flag_q  <= 1'b0;
            done_q       <= 1'b0;
            write_en_q   <= 1'b0;
            data_q       <= 8'h00;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_owner_q <= last_owner_d;
            cnt_q        <= cnt_d;
            last_flag_q  <= last_flag_d;
            done_q       <= done_d;
            write_en_q   <= write_en_d;
            data_q       <= data_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign req_ready = (state_q == ST_XFER) ? grant_q : '0;
    assign grant     = grant_q;
    assign write_en  = write_en_q;
    assign data      = data_q;
    assign busy      = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_lcd_msg_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd_msg_sched
// Description : Self-checking bench for lcd_msg_sched. Requesters are driven
//               from per-requester byte queues with random valid gaps. A
//               transaction-level model predicts ownership (round-robin over
//               the valid vector), the accept windows, the cycle of every
//               write strobe and its byte, the trailing CR and the release of
//               the port, all from cycle arithmetic on GAP.
// Revision    : 1.0  initial release
// ============================================================================
module tb_lcd_msg_sched;

    localparam int NREQ = 2;
    localparam int GAP  = 4;
    localparam int NONE = -1;
    localparam int FAR  = 32'h3fff_ffff;
    localparam int QD   = 64;

    logic                clock     = 1'b0;
    logic                reset     = 1'b0;
    logic [NREQ-1:0]     req_valid = '0;
    logic [8*NREQ-1:0]   req_data  = '0;
    logic [NREQ-1:0]     req_last  = '0;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ-1:0]     grant;
    logic                write_en;
    logic [7:0]          data;
    logic                busy;

    lcd_msg_sched #(
        .NREQ       (NREQ),
        .GAP_CYCLES (GAP)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .grant     (grant),
        .write_en  (write_en),
        .data      (data),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    // ------------------------------------------------------------------------
    // Bench state
    // ------------------------------------------------------------------------
    int cyc      = 0;
    int n_total  = 0;
    int n_pass   = 0;
    int n_writes = 0;

    // Reference model
    int         owner      = NONE;
    int         last_owner = NREQ - 1;
    int         rdy_from   = FAR;
    int         we_at      = FAR;
    int         cr_at      = FAR;
    int         drop_at    = FAR;
    logic [7:0] exp_byte   = 8'h00;
    bit         exp_data_zero = 1'b1;

    // Requester byte queues
    logic [7:0] q_byte [NREQ][QD];
    bit         q_last [NREQ][QD];
    int         q_head [NREQ];
    int         q_tail [NREQ];
    bit         auto_gen [NREQ];
    bit         stall [NREQ];
    int         p_valid = 100;
    int         p_new   = 100;
    int         max_len = 4;

    // Observed owners, one entry each time grant leaves zero
    int              obs_grants[$];
    logic [NREQ-1:0] prev_grant = '0;

    // ------------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    endtask

    function automatic int rr_expect(input logic [NREQ-1:0] v, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            int c;
            c = (last + k) % NREQ;
            if (v[c]) return c;
        end
        return NONE;
    endfunction

    function automatic bit queues_empty();
        for (int r = 0; r < NREQ; r++)
            if (q_head[r] != q_tail[r]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic push_byte(input int r, input logic [7:0] b, input bit l);
        q_byte[r][q_tail[r]] = b;
        q_last[r][q_tail[r]] = l;
        q_tail[r]++;
    endtask

    task automatic push_msg_random(input int r);
        int len;
        len = 1 + int'($urandom_range(max_len - 1));
        for (int k = 0; k < len; k++) begin
            logic [7:0] b;
            b = ($urandom_range(7) == 0) ? 8'h0D : 8'($urandom);
            push_byte(r, b, k == len - 1);
        end
    endtask

    // ------------------------------------------------------------------------
    // Per-cycle activity: drive inputs, predict, clock, compare
    // ------------------------------------------------------------------------
    task automatic drive_inputs();
        for (int r = 0; r < NREQ; r++) begin
            if (q_head[r] == q_tail[r]) begin
                q_head[r] = 0;
                q_tail[r] = 0;
                if (auto_gen[r] && reset && $urandom_range(99) < p_new) push_msg_random(r);
            end
            if (reset && !stall[r] && q_head[r] != q_tail[r] && $urandom_range(99) < p_valid) begin
                req_valid[r]       = 1'b1;
                req_data[8*r +: 8] = q_byte[r][q_head[r]];
                req_last[r]        = q_last[r][q_head[r]];
            end else begin
                req_valid[r]       = 1'b0;
                req_data[8*r +: 8] = 8'($urandom);
                req_last[r]        = 1'($urandom);
            end
        end
    endtask

    // Advances the model from sample cyc to sample cyc+1 given driven inputs.
    task automatic model_advance();
        int s;
        s = cyc;
        if (!reset) begin
            owner = NONE; last_owner = NREQ - 1;
            rdy_from = FAR; we_at = FAR; cr_at = FAR; drop_at = FAR;
            exp_data_zero = 1'b1;
            for (int r = 0; r < NREQ; r++) begin
                q_head[r] = 0;
                q_tail[r] = 0;
            end
            return;
        end
        exp_data_zero = 1'b0;
        if (owner == NONE) begin
            int c;
            c = rr_expect(req_valid, last_owner);
            if (c != NONE) begin
                owner    = c;
                rdy_from = s + 1;
            end
        end else if (s >= rdy_from && req_valid[owner]) begin
            exp_byte = req_data[8*owner +: 8];
            we_at    = s + 1;
            rdy_from = FAR;
            if (req_last[owner]) begin
                cr_at   = s + 2 + GAP;
                drop_at = s + 2 + 2 * GAP;
            end else begin
                rdy_from = s + 1 + GAP;
            end
            q_head[owner]++;
        end else if (drop_at == s + 1) begin
            last_owner = owner;
            owner      = NONE;
            drop_at    = FAR;
        end
    endtask

    task automatic compare_outputs();
        logic [NREQ-1:0] g_exp;
        bit              we_exp;
        g_exp  = (owner == NONE) ? '0 : NREQ'(1 << owner);
        we_exp = (cyc == we_at) || (cyc == cr_at);
        check("grant",     32'(grant),     32'(g_exp));
        check("busy",      32'(busy),      32'(owner != NONE));
        check("req_ready", 32'(req_ready), (owner != NONE && cyc >= rdy_from) ? 32'(g_exp) : 32'd0);
        check("write_en",  32'(write_en),  32'(we_exp));
        if (we_exp) check("data", 32'(data), (cyc == cr_at) ? 32'h0D : 32'(exp_byte));
        if (exp_data_zero) check("data_rst", 32'(data), 32'd0);
        if (write_en) n_writes++;
        if (grant != '0 && prev_grant == '0) obs_grants.push_back(int'(grant));
        prev_grant = grant;
    endtask

    task automatic cycle_step();
        drive_inputs();
        model_advance();
        @(posedge clock);
        #1;
        cyc++;
        compare_outputs();
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while (!(owner == NONE && queues_empty()) && k < budget) begin
            cycle_step();
            k++;
        end
        check("drain_done", 32'(owner == NONE && queues_empty()), 32'd1);
    endtask

    task automatic wait_write(input int budget);
        int w, k;
        w = n_writes;
        k = 0;
        while (n_writes == w && k < budget) begin
            cycle_step();
            k++;
        end
        check("write_seen", 32'(n_writes != w), 32'd1);
    endtask

    task automatic pulse_reset(input int n);
        reset = 1'b0;
        repeat (n) cycle_step();
        reset = 1'b1;
    endtask

    // ------------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------------
    initial begin
        int w0, b0, held;

        // Reset values
        pulse_reset(3);

        // Single message "HI"
        w0 = n_writes;
        push_byte(0, 8'h48, 1'b0);
        push_byte(0, 8'h49, 1'b1);
        drain(200);
        check("s1_writes", 32'(n_writes - w0), 32'd3);

        // Contention straight after reset
        pulse_reset(2);
        b0 = obs_grants.size();
        push_byte(0, 8'h30, 1'b0); push_byte(0, 8'h31, 1'b1);
        push_byte(1, 8'h40, 1'b0); push_byte(1, 8'h41, 1'b1);
        drain(300);
        check("s2_first",  32'(obs_grants[b0]),     32'd1);
        check("s2_second", 32'(obs_grants[b0 + 1]), 32'd2);
        push_byte(0, 8'h32, 1'b1);
        push_byte(1, 8'h42, 1'b1);
        drain(300);
        check("s2_rep_first", 32'(obs_grants[b0 + 2]), 32'd1);
        push_byte(1, 8'h43, 1'b1);
        drain(200);
        check("s2_r1_alone", 32'(obs_grants[b0 + 4]), 32'd2);

        // Owner stalls for 50 cycles after its first byte
        push_byte(0, 8'h41, 1'b0); push_byte(0, 8'h42, 1'b0); push_byte(0, 8'h43, 1'b1);
        w0 = n_writes;
        wait_write(50);
        stall[0] = 1'b1;
        held = 0;
        repeat (50) begin
            cycle_step();
            if (grant == 2'b01) held++;
        end
        check("s3_no_write", 32'(n_writes - w0), 32'd1);
        check("s3_grant_held", 32'(held), 32'd50);
        stall[0] = 1'b0;
        drain(200);
        check("s3_writes", 32'(n_writes - w0), 32'd4);

        // Reset two cycles after the first write of a message
        push_byte(0, 8'h50, 1'b0); push_byte(0, 8'h51, 1'b0);
        push_byte(0, 8'h52, 1'b0); push_byte(0, 8'h53, 1'b1);
        wait_write(50);
        repeat (2) cycle_step();
        pulse_reset(1);
        w0 = n_writes;
        repeat (20) cycle_step();
        check("s4_no_cr", 32'(n_writes - w0), 32'd0);
        b0 = obs_grants.size();
        push_byte(0, 8'h60, 1'b1);
        push_byte(1, 8'h61, 1'b1);
        drain(200);
        check("s4_first_grant", 32'(obs_grants[b0]), 32'd1);

        // Fairness with continuous one-byte messages
        pulse_reset(1);
        b0 = obs_grants.size();
        w0 = n_writes;
        max_len = 1; p_valid = 100; p_new = 100;
        auto_gen[0] = 1'b1; auto_gen[1] = 1'b1;
        repeat (120) cycle_step();
        auto_gen[0] = 1'b0; auto_gen[1] = 1'b0;
        drain(300);
        for (int k = b0; k < obs_grants.size(); k++)
            check("s5_alternate", 32'(obs_grants[k]), ((k - b0) % 2 == 0) ? 32'd1 : 32'd2);
        check("s5_cr_per_msg", 32'(n_writes - w0), 32'(2 * (obs_grants.size() - b0)));

        // 0x0D inside a message is forwarded, then the automatic CR
        w0 = n_writes;
        push_byte(1, 8'h41, 1'b0); push_byte(1, 8'h0D, 1'b0); push_byte(1, 8'h42, 1'b1);
        drain(300);
        check("s6_writes", 32'(n_writes - w0), 32'd4);

        // Random traffic with random valid gaps
        max_len = 4; p_valid = 75; p_new = 30;
        auto_gen[0] = 1'b1; auto_gen[1] = 1'b1;
        repeat (3000) cycle_step();
        auto_gen[0] = 1'b0; auto_gen[1] = 1'b0;
        p_valid = 100;
        drain(1000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
